bus_endpoint: RTL and testbench



---
 rtl/bus_endpoint_if.sv | 31 +++
 rtl/bus_endpoint.sv | 108 ++++++++++
 tb/tb_bus_endpoint.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_endpoint_if.sv
// Handshake bundle between a bus_endpoint and its host plus bus arbiter.
// Latency: none (signal bundle only).
// Backpressure: tx_full toward the host; pndng/pop toward the bus; rx has no stall toward the bus.
// Ports: host side tx_push/tx_data/tx_full, rx_pop/rx_data/rx_pndng;
//        bus side pndng/D_pop/pop (drain tx), push/D_push (fill rx).
//        slave = the endpoint, master = whoever drives host and bus.
interface bus_endpoint_if #(
  parameter int pckg_sz = 16
) ();
  logic               tx_push;
  logic [pckg_sz-1:0] tx_data;
  logic               tx_full;
  logic               rx_pop;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_pndng;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport slave (
    input  tx_push, tx_data, rx_pop, pop, push, D_push,
    output tx_full, rx_data, rx_pndng, pndng, D_pop
  );

  modport master (
    output tx_push, tx_data, rx_pop, pop, push, D_push,
    input  tx_full, rx_data, rx_pndng, pndng, D_pop
  );
endinterface

// File: rtl/bus_endpoint.sv
// Device-side bus terminal: tx FIFO (host fills, bus drains) and rx FIFO (bus fills, host drains).
// Latency: one cycle from push to visibility on D_pop/rx_data; pops advance the head on the same edge.
// Backpressure: host sees tx_full; rx cannot stall the bus, so overflow is dropped and counted.
// Ports: clk, reset (async, active-low), bus (bus_endpoint_if.slave),
//        drop_cnt/misroute_cnt/underflow_cnt (8-bit saturating debug counters).
module bus_endpoint #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] my_id     = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  bus_endpoint_if.slave  bus,
  output logic [7:0]     drop_cnt,
  output logic [7:0]     misroute_cnt,
  output logic [7:0]     underflow_cnt
);

  localparam int            aw       = $clog2(depth);
  localparam logic [aw:0]   full_lvl = (aw+1)'(depth);
  localparam logic [aw:0]   cnt_one  = (aw+1)'(1);
  localparam logic [aw-1:0] ptr_one  = aw'(1);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];

  logic [aw-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [aw:0]   tx_cnt, rx_cnt, tx_cnt_nxt, rx_cnt_nxt;
  logic          tx_full_q, tx_pndng_q, rx_full_q, rx_pndng_q;

  logic tx_do_pop, tx_do_push, rx_do_pop, rx_do_push;
  logic underflow, dropped, misroute;
  logic [7:0] dest;

  // A full FIFO still accepts a write when its head leaves on the same edge.
  // A pop on an empty tx FIFO never passes the simultaneous push through.
  assign tx_do_pop  = bus.pop && tx_pndng_q;
  assign tx_do_push = bus.tx_push && (!tx_full_q || tx_do_pop);
  assign underflow  = bus.pop && !tx_pndng_q;

  assign rx_do_pop  = bus.rx_pop && rx_pndng_q;
  assign rx_do_push = bus.push && (!rx_full_q || rx_do_pop);
  assign dropped    = bus.push && !rx_do_push;

  // Destination is checked on every bus push, stored or not; nothing is filtered.
  assign dest     = bus.D_push[pckg_sz-1 -: 8];
  assign misroute = bus.push && (dest != my_id) && (dest != broadcast);

  always_comb begin
    tx_cnt_nxt = tx_cnt;
    if (tx_do_push && !tx_do_pop)      tx_cnt_nxt = tx_cnt + cnt_one;
    else if (tx_do_pop && !tx_do_push) tx_cnt_nxt = tx_cnt - cnt_one;
  end

  always_comb begin
    rx_cnt_nxt = rx_cnt;
    if (rx_do_push && !rx_do_pop)      rx_cnt_nxt = rx_cnt + cnt_one;
    else if (rx_do_pop && !rx_do_push) rx_cnt_nxt = rx_cnt - cnt_one;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr         <= '0;
      tx_rd         <= '0;
      rx_wr         <= '0;
      rx_rd         <= '0;
      tx_cnt        <= '0;
      rx_cnt        <= '0;
      tx_full_q     <= 1'b0;
      tx_pndng_q    <= 1'b0;
      rx_full_q     <= 1'b0;
      rx_pndng_q    <= 1'b0;
      drop_cnt      <= 8'd0;
      misroute_cnt  <= 8'd0;
      underflow_cnt <= 8'd0;
    end else begin
      if (tx_do_push) tx_wr <= tx_wr + ptr_one;
      if (tx_do_pop)  tx_rd <= tx_rd + ptr_one;
      if (rx_do_push) rx_wr <= rx_wr + ptr_one;
      if (rx_do_pop)  rx_rd <= rx_rd + ptr_one;

      tx_cnt     <= tx_cnt_nxt;
      rx_cnt     <= rx_cnt_nxt;
      tx_full_q  <= (tx_cnt_nxt == full_lvl);
      tx_pndng_q <= (tx_cnt_nxt != '0);
      rx_full_q  <= (rx_cnt_nxt == full_lvl);
      rx_pndng_q <= (rx_cnt_nxt != '0);

      if (dropped && drop_cnt != 8'hFF)        drop_cnt      <= drop_cnt + 8'd1;
      if (misroute && misroute_cnt != 8'hFF)   misroute_cnt  <= misroute_cnt + 8'd1;
      if (underflow && underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 8'd1;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wr] <= bus.tx_data;
    if (rx_do_push) rx_mem[rx_wr] <= bus.D_push;
  end

  assign bus.tx_full  = tx_full_q;
  assign bus.pndng    = tx_pndng_q;
  assign bus.rx_pndng = rx_pndng_q;
  assign bus.D_pop    = tx_pndng_q ? tx_mem[tx_rd] : '0;
  assign bus.rx_data  = rx_pndng_q ? rx_mem[rx_rd] : '0;

endmodule

// File: tb/tb_bus_endpoint.sv
// Self-checking bench for bus_endpoint: queue-based reference model plus directed scenarios.
// Latency: model state is updated on each rising edge, outputs compared on each falling edge.
// Backpressure: model applies tx_full / rx-full acceptance rules with plain queue sizes.
module tb_bus_endpoint;

  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_endpoint_if #(.pckg_sz(16)) bif ();
  logic [7:0] drop_cnt, misroute_cnt, underflow_cnt;

  bus_endpoint #(
    .pckg_sz(16), .depth(DEPTH), .my_id(8'h00), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bif),
    .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt), .underflow_cnt(underflow_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: queue contents and plain integer counters.
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  int m_drop = 0, m_mis = 0, m_und = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      m_drop = 0;
      m_mis  = 0;
      m_und  = 0;
    end else begin
      bit tx_pop_ok, rx_pop_ok, tx_acc, rx_acc;
      tx_pop_ok = bif.pop && (tx_q.size() > 0);
      tx_acc    = bif.tx_push && ((tx_q.size() < DEPTH) || tx_pop_ok);
      if (bif.pop && tx_q.size() == 0) m_und = (m_und < 255) ? m_und + 1 : 255;
      if (tx_pop_ok) void'(tx_q.pop_front());
      if (tx_acc) tx_q.push_back(bif.tx_data);

      rx_pop_ok = bif.rx_pop && (rx_q.size() > 0);
      rx_acc    = bif.push && ((rx_q.size() < DEPTH) || rx_pop_ok);
      if (bif.push && bif.D_push[15:8] != 8'h00 && bif.D_push[15:8] != 8'hFF)
        m_mis = (m_mis < 255) ? m_mis + 1 : 255;
      if (bif.push && !rx_acc) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      if (rx_pop_ok) void'(rx_q.pop_front());
      if (rx_acc) rx_q.push_back(bif.D_push);
    end
  end

  // The single compare process against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] exp_dpop, exp_rx;
      exp_dpop = (tx_q.size() > 0) ? tx_q[0] : 16'h0;
      exp_rx   = (rx_q.size() > 0) ? rx_q[0] : 16'h0;
      chk("pndng",     32'(bif.pndng),    32'(tx_q.size() != 0));
      chk("tx_full",   32'(bif.tx_full),  32'(tx_q.size() == DEPTH));
      chk("D_pop",     32'(bif.D_pop),    32'(exp_dpop));
      chk("rx_pndng",  32'(bif.rx_pndng), 32'(rx_q.size() != 0));
      chk("rx_data",   32'(bif.rx_data),  32'(exp_rx));
      chk("drop_cnt",  32'(drop_cnt),     32'(m_drop));
      chk("mis_cnt",   32'(misroute_cnt), 32'(m_mis));
      chk("und_cnt",   32'(underflow_cnt),32'(m_und));
    end
  end

  task automatic idle();
    bif.tx_push = 1'b0; bif.tx_data = 16'h0; bif.rx_pop = 1'b0;
    bif.pop = 1'b0; bif.push = 1'b0; bif.D_push = 16'h0;
  endtask

  // Holds one set of inputs across exactly one rising edge, returns at falling edge + 1.
  task automatic step(input bit tp, input logic [15:0] td, input bit rp,
                      input bit pp, input bit ps, input logic [15:0] dps);
    bif.tx_push = tp; bif.tx_data = td; bif.rx_pop = rp;
    bif.pop = pp; bif.push = ps; bif.D_push = dps;
    @(negedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_pndng",   32'(bif.pndng),    32'h0);
    chk("rst_tx_full", 32'(bif.tx_full),  32'h0);
    chk("rst_D_pop",   32'(bif.D_pop),    32'h0);
    chk("rst_rx_data", 32'(bif.rx_data),  32'h0);
    chk("rst_cnts",    32'({drop_cnt, misroute_cnt, underflow_cnt}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Three host pushes, then three bus pops in order.
    step(1, 16'h0201, 0, 0, 0, 0);
    chk("t1_pndng", 32'(bif.pndng), 32'h1);
    chk("t1_head",  32'(bif.D_pop), 32'h0201);
    step(1, 16'h0302, 0, 0, 0, 0);
    step(1, 16'h0403, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t1_pop1", 32'(bif.D_pop), 32'h0302);
    step(0, 0, 0, 1, 0, 0);
    chk("t1_pop2", 32'(bif.D_pop), 32'h0403);
    step(0, 0, 0, 1, 0, 0);
    chk("t1_empty_pndng", 32'(bif.pndng), 32'h0);
    chk("t1_empty_dpop",  32'(bif.D_pop), 32'h0);

    // Fill tx, overflow ignored, push-with-pop when full, drain across the wrap.
    for (int k = 1; k <= 8; k++) step(1, 16'h0100 + 16'(k), 0, 0, 0, 0);
    chk("t2_full", 32'(bif.tx_full), 32'h1);
    step(1, 16'h0109, 0, 0, 0, 0);
    chk("t2_ign_full", 32'(bif.tx_full), 32'h1);
    chk("t2_ign_head", 32'(bif.D_pop),   32'h0101);
    step(1, 16'h0109, 0, 1, 0, 0);
    chk("t2_pp_full", 32'(bif.tx_full), 32'h1);
    for (int k = 2; k <= 9; k++) begin
      chk("t2_drain", 32'(bif.D_pop), 32'h0100 + 32'(k));
      step(0, 0, 0, 1, 0, 0);
    end
    chk("t2_drained", 32'(bif.pndng), 32'h0);

    // Rx overflow: 9 pushes addressed to us, no host pops.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, 16'h00A0 + 16'(i));
    chk("t3_drop", 32'(drop_cnt),     32'h1);
    chk("t3_mis",  32'(misroute_cnt), 32'h0);
    chk("t3_head", 32'(bif.rx_data),  32'h00A0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", 32'(bif.rx_data), 32'h00A0 + 32'(i));
      step(0, 0, 1, 0, 0, 0);
    end
    chk("t3_empty", 32'(bif.rx_pndng), 32'h0);

    // Destination check: one misroute, all three stored.
    step(0, 0, 0, 0, 1, 16'h05AA);
    step(0, 0, 0, 0, 1, 16'hFF11);
    step(0, 0, 0, 0, 1, 16'h0022);
    chk("t4_mis", 32'(misroute_cnt), 32'h1);
    chk("t4_r0", 32'(bif.rx_data), 32'h05AA);
    step(0, 0, 1, 0, 0, 0);
    chk("t4_r1", 32'(bif.rx_data), 32'hFF11);
    step(0, 0, 1, 0, 0, 0);
    chk("t4_r2", 32'(bif.rx_data), 32'h0022);
    step(0, 0, 1, 0, 0, 0);

    // Underflow saturation, then a clean push.
    for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 0, 0);
    chk("t5_und_sat", 32'(underflow_cnt), 32'hFF);
    chk("t5_pndng",   32'(bif.pndng),     32'h0);
    step(1, 16'h0BEE, 0, 0, 0, 0);
    chk("t5_head", 32'(bif.D_pop), 32'h0BEE);
    step(0, 0, 0, 1, 0, 0);

    // Mid-cycle async reset with both FIFOs holding data.
    for (int i = 0; i < 5; i++) step(1, 16'h0300 + 16'(i), 0, 0, (i < 3), 16'h00C0 + 16'(i));
    chk("t6_pre_pndng", 32'(bif.pndng),    32'h1);
    chk("t6_pre_rx",    32'(bif.rx_pndng), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pndng", 32'(bif.pndng),    32'h0);
    chk("t6_rst_rx",    32'(bif.rx_pndng), 32'h0);
    chk("t6_rst_cnts",  32'({drop_cnt, misroute_cnt, underflow_cnt}), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    step(1, 16'h0107, 0, 0, 0, 0);
    chk("t6_head",  32'(bif.D_pop),   32'h0107);
    chk("t6_full",  32'(bif.tx_full), 32'h0);
    step(0, 0, 0, 1, 0, 0);
    chk("t6_one",   32'(bif.pndng),   32'h0);

    // Randomized traffic with alternating fill-heavy and drain-heavy phases.
    for (int blk = 0; blk < 16; blk++) begin
      int wp, rp;
      wp = (blk % 2 == 0) ? 80 : 25;
      rp = (blk % 2 == 0) ? 25 : 80;
      for (int c = 0; c < 150; c++) begin
        logic [15:0] d;
        int sel;
        sel = int'($urandom_range(0, 3));
        d = 16'($urandom);
        if (sel == 0) d[15:8] = 8'h00;
        else if (sel == 1) d[15:8] = 8'hFF;
        step(($urandom_range(0, 99) < wp), 16'($urandom),
             ($urandom_range(0, 99) < rp),
             ($urandom_range(0, 99) < rp),
             ($urandom_range(0, 99) < wp), d);
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
